// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO on an inferred RAM, with standard or first-word-fall-through
// read mode, occupancy count, programmable almost-full/empty flags and error pulses.
module fifo_sync_param #(
  parameter int DATA_W    = 11,
  parameter int DEPTH     = 2048,
  parameter int FWFT      = 0,
  parameter int PFULL_TH  = DEPTH - 4,
  parameter int PEMPTY_TH = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              prog_full,
  output logic              prog_empty,
  output logic [CNT_W-1:0]  data_count,
  output logic              wr_err,
  output logic              rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PFULL_C  = CNT_W'(PFULL_TH);
  localparam logic [CNT_W-1:0] PEMPTY_C = CNT_W'(PEMPTY_TH);

  // Handshake: a write is taken when wr_en && !full and a read when rd_en && !empty,
  // both judged on the registered flags; a refused request only raises its error pulse.

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              pfull_q, pfull_d;
  logic              pempty_q, pempty_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;
  logic              pf_vld_q, pf_vld_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rd_data_q;

  logic wr_acc;
  logic rd_acc;
  logic ram_rd;
  logic out_load;
  logic pf_free;

  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    out_load = 1'b0;
    pf_free  = 1'b0;
    ram_rd   = 1'b0;
    if (FWFT != 0) begin
      // The RAM read register acts as a prefetch stage; it refills in the same cycle the
      // output register takes its word, so consecutive pops see no bubble.
      out_load = pf_vld_q && (!out_vld_q || rd_acc);
      pf_free  = !pf_vld_q || out_load;
      ram_rd   = (ram_cnt_q != '0) && pf_free;
    end else begin
      ram_rd   = rd_acc;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + AW'(ram_rd);
    ram_cnt_d = ram_cnt_q + CNT_W'(wr_acc) - CNT_W'(ram_rd);
    cnt_d     = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

    pf_vld_d  = pf_vld_q;
    out_vld_d = out_vld_q;
    dout_d    = dout_q;
    if (FWFT != 0) begin
      if (ram_rd) begin
        pf_vld_d = 1'b1;
      end else if (out_load) begin
        pf_vld_d = 1'b0;
      end
      if (out_load) begin
        out_vld_d = 1'b1;
        dout_d    = rd_data_q;
      end else if (rd_acc) begin
        out_vld_d = 1'b0;
      end
    end

    full_d   = (cnt_d == DEPTH_C);
    empty_d  = (FWFT != 0) ? !out_vld_d : (cnt_d == '0);
    pfull_d  = (cnt_d >= PFULL_C);
    pempty_d = (cnt_d <= PEMPTY_C);
    wr_err_d = wr_en && full_q;
    rd_err_d = rd_en && empty_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      pfull_q   <= 1'b0;
      pempty_q  <= 1'b1;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      pf_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      pfull_q   <= pfull_d;
      pempty_q  <= pempty_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      pf_vld_q  <= pf_vld_d;
      out_vld_q <= out_vld_d;
      dout_q    <= dout_d;
    end
  end

  // RAM array is never reset so it maps onto block or distributed memory.
  always_ff @(posedge clk) begin
    if (wr_acc && !srst) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_q <= '0;
    end else if (ram_rd) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign dout       = (FWFT != 0) ? dout_q : rd_data_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign prog_full  = pfull_q;
  assign prog_empty = pempty_q;
  assign data_count = cnt_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: one standard-mode and one FWFT instance (DEPTH=16),
// each compared cycle by cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW  = 11;
  localparam int DEP = 16;
  localparam int PF  = 12;
  localparam int PE  = 4;
  localparam int CW  = $clog2(DEP) + 1;
  localparam int VW  = DW + CW + 6;

  logic          clk = 1'b0;
  logic          srst [2];
  logic [DW-1:0] din [2];
  logic          wr_en [2];
  logic          rd_en [2];
  logic [DW-1:0] dout [2];
  logic          full [2];
  logic          empty [2];
  logic          prog_full [2];
  logic          prog_empty [2];
  logic [CW-1:0] data_count [2];
  logic          wr_err [2];
  logic          rd_err [2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: expected queues with the edge index at which each word was written.
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            stamp_q1 [$];
  logic [DW-1:0] last_dout0;
  logic          exp_wr_err [2];
  logic          exp_rd_err [2];

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0), .PFULL_TH(PF), .PEMPTY_TH(PE)) u_std (
    .clk(clk), .srst(srst[0]), .din(din[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .dout(dout[0]), .full(full[0]), .empty(empty[0]), .prog_full(prog_full[0]),
    .prog_empty(prog_empty[0]), .data_count(data_count[0]), .wr_err(wr_err[0]), .rd_err(rd_err[0])
  );

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1), .PFULL_TH(PF), .PEMPTY_TH(PE)) u_fwft (
    .clk(clk), .srst(srst[1]), .din(din[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .dout(dout[1]), .full(full[1]), .empty(empty[1]), .prog_full(prog_full[1]),
    .prog_empty(prog_empty[1]), .data_count(data_count[1]), .wr_err(wr_err[1]), .rd_err(rd_err[1])
  );

  always #5 clk = ~clk;

  function automatic int msize(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // FWFT: a word can be shown no earlier than two edges after it was written.
  function automatic bit mvisible(input int m);
    if (m == 0) return exp_q0.size() > 0;
    return (exp_q1.size() > 0) && (cyc >= stamp_q1[0] + 2);
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int m);
    int n;
    logic [DW-1:0] d;
    n = msize(m);
    if (m == 0) d = last_dout0;
    else d = mvisible(1) ? exp_q1[0] : {DW{1'b0}};
    return {d, n == DEP, !mvisible(m), n >= PF, n <= PE, CW'(n), exp_wr_err[m], exp_rd_err[m]};
  endfunction

  function automatic logic [VW-1:0] act_vec(input int m);
    logic [DW-1:0] d;
    d = (m == 1 && !mvisible(1)) ? {DW{1'b0}} : dout[m];
    return {d, full[m], empty[m], prog_full[m], prog_empty[m], data_count[m], wr_err[m], rd_err[m]};
  endfunction

  task automatic cycle(input int m, input logic w, input logic r, input logic [DW-1:0] d,
                       input logic rst);
    bit full_pre, empty_pre;
    int o;
    logic [DW-1:0] popped;
    o = 1 - m;
    full_pre  = (msize(m) == DEP);
    empty_pre = !mvisible(m);
    srst[m] = rst; wr_en[m] = w; rd_en[m] = r; din[m] = d;
    srst[o] = 1'b0; wr_en[o] = 1'b0; rd_en[o] = 1'b0;
    @(posedge clk);
    cyc++;
    exp_wr_err[o] = 1'b0;
    exp_rd_err[o] = 1'b0;
    if (rst) begin
      if (m == 0) begin exp_q0.delete(); last_dout0 = '0; end
      else begin exp_q1.delete(); stamp_q1.delete(); end
      exp_wr_err[m] = 1'b0;
      exp_rd_err[m] = 1'b0;
    end else begin
      exp_wr_err[m] = w && full_pre;
      exp_rd_err[m] = r && empty_pre;
      if (r && !empty_pre) begin
        if (m == 0) begin popped = exp_q0.pop_front(); last_dout0 = popped; end
        else begin popped = exp_q1.pop_front(); void'(stamp_q1.pop_front()); end
      end
      if (w && !full_pre) begin
        if (m == 0) exp_q0.push_back(d);
        else begin exp_q1.push_back(d); stamp_q1.push_back(cyc); end
      end
    end
    #1;
  endtask

  task automatic test_reset(input int m);
    cycle(m, 1'b1, 1'b1, DW'(7), 1'b1);
    cycle(m, 1'b0, 1'b0, '0, 1'b1);
    tests++;
    if (act_vec(m) !== exp_vec(m)) begin
      fails++; $display("FAIL reset_vec m=%0d got %h want %h", m, act_vec(m), exp_vec(m));
    end
    tests++;
    if ({dout[m], empty[m], full[m], prog_empty[m], prog_full[m], data_count[m], wr_err[m], rd_err[m]}
        !== {{DW{1'b0}}, 4'b1010, {CW{1'b0}}, 2'b00}) begin
      fails++; $display("FAIL reset_state m=%0d dout=%h empty=%b full=%b count=%0d", m, dout[m],
                        empty[m], full[m], data_count[m]);
    end
  endtask

  task automatic test_fill_drain;
    test_reset(0);
    for (int i = 0; i < DEP; i++) cycle(0, 1'b1, 1'b0, DW'(i), 1'b0);
    tests++;
    if (full[0] !== 1'b1 || data_count[0] !== CW'(DEP)) begin
      fails++; $display("FAIL fill_full got full=%b count=%0d want 1/16", full[0], data_count[0]);
    end
    cycle(0, 1'b1, 1'b0, DW'(99), 1'b0);
    tests++;
    if (wr_err[0] !== 1'b1 || data_count[0] !== CW'(DEP)) begin
      fails++; $display("FAIL overflow got wr_err=%b count=%0d want 1/16", wr_err[0], data_count[0]);
    end
    for (int i = 0; i < DEP; i++) begin
      cycle(0, 1'b0, 1'b1, '0, 1'b0);
      tests++;
      if (dout[0] !== DW'(i)) begin
        fails++; $display("FAIL drain_order i=%0d got %h want %h", i, dout[0], DW'(i));
      end
    end
    tests++;
    if (empty[0] !== 1'b1 || data_count[0] !== '0) begin
      fails++; $display("FAIL drain_empty got empty=%b count=%0d", empty[0], data_count[0]);
    end
    cycle(0, 1'b0, 1'b1, '0, 1'b0);
    tests++;
    if (rd_err[0] !== 1'b1 || dout[0] !== DW'(DEP - 1)) begin
      fails++; $display("FAIL underflow got rd_err=%b dout=%h want 1/%h", rd_err[0], dout[0], DW'(DEP - 1));
    end
    cycle(0, 1'b1, 1'b1, DW'(300), 1'b0);
    tests++;
    if (act_vec(0) !== exp_vec(0) || rd_err[0] !== 1'b1 || data_count[0] !== CW'(1)) begin
      fails++; $display("FAIL wr_rd_empty got %h want %h", act_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_fwft_single;
    test_reset(1);
    cycle(1, 1'b1, 1'b0, DW'('h2A), 1'b0);
    tests++;
    if (empty[1] !== 1'b1 || data_count[1] !== CW'(1)) begin
      fails++; $display("FAIL fwft_lat0 got empty=%b count=%0d want 1/1", empty[1], data_count[1]);
    end
    cycle(1, 1'b0, 1'b0, '0, 1'b0);
    tests++;
    if (empty[1] !== 1'b1) begin
      fails++; $display("FAIL fwft_lat1 got empty=%b want 1", empty[1]);
    end
    cycle(1, 1'b0, 1'b0, '0, 1'b0);
    tests++;
    if (empty[1] !== 1'b0 || dout[1] !== DW'('h2A)) begin
      fails++; $display("FAIL fwft_lat2 got empty=%b dout=%h want 0/02a", empty[1], dout[1]);
    end
    cycle(1, 1'b0, 1'b1, '0, 1'b0);
    tests++;
    if (empty[1] !== 1'b1 || data_count[1] !== '0) begin
      fails++; $display("FAIL fwft_pop got empty=%b count=%0d want 1/0", empty[1], data_count[1]);
    end
  endtask

  task automatic test_back_to_back(input int m);
    test_reset(m);
    for (int i = 0; i < 8; i++) cycle(m, 1'b1, 1'b0, DW'($urandom_range(0, 2047)), 1'b0);
    cycle(m, 1'b0, 1'b0, '0, 1'b0);
    cycle(m, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(m, 1'b1, 1'b1, DW'($urandom_range(0, 2047)), 1'b0);
      tests++;
      if (act_vec(m) !== exp_vec(m) || data_count[m] !== CW'(8) || wr_err[m] || rd_err[m]) begin
        fails++; $display("FAIL stream m=%0d i=%0d got %h want %h", m, i, act_vec(m), exp_vec(m));
      end
    end
  endtask

  task automatic test_wrap(input int m);
    int pushed;
    int n;
    bit w, r;
    test_reset(m);
    pushed = 0;
    n = 0;
    while ((pushed < 3 * DEP + 5 || msize(m) > 0) && n < 3000) begin
      w = ($urandom_range(0, 1) == 1) && (pushed < 3 * DEP + 5) && (msize(m) < DEP);
      r = ($urandom_range(0, 2) != 0) && mvisible(m);
      if (w) pushed++;
      cycle(m, w, r, DW'($urandom), 1'b0);
      n++;
      tests++;
      if (act_vec(m) !== exp_vec(m) || wr_err[m] || rd_err[m]) begin
        fails++; $display("FAIL wrap m=%0d cyc=%0d got %h want %h", m, n, act_vec(m), exp_vec(m));
      end
    end
    tests++;
    if (n >= 3000) begin
      fails++; $display("FAIL wrap_timeout m=%0d pushed=%0d left=%0d", m, pushed, msize(m));
    end
  endtask

  task automatic test_prog_flags;
    test_reset(0);
    for (int k = 1; k <= DEP; k++) begin
      cycle(0, 1'b1, 1'b0, DW'(k), 1'b0);
      tests++;
      if (prog_full[0] !== (k >= 12) || prog_empty[0] !== (k <= 4)) begin
        fails++; $display("FAIL prog_up k=%0d got pf=%b pe=%b", k, prog_full[0], prog_empty[0]);
      end
    end
    for (int k = DEP - 1; k >= 0; k--) begin
      cycle(0, 1'b0, 1'b1, '0, 1'b0);
      tests++;
      if (prog_full[0] !== (k >= 12) || prog_empty[0] !== (k <= 4)) begin
        fails++; $display("FAIL prog_down k=%0d got pf=%b pe=%b", k, prog_full[0], prog_empty[0]);
      end
    end
  endtask

  task automatic test_reset_mid(input int m);
    test_reset(m);
    for (int i = 0; i < 9; i++) cycle(m, 1'b1, 1'b0, DW'($urandom_range(1, 2047)), 1'b0);
    cycle(m, 1'b0, 1'b1, '0, 1'b0);
    cycle(m, 1'b0, 1'b1, '0, 1'b1);
    tests++;
    if (data_count[m] !== '0 || empty[m] !== 1'b1 || dout[m] !== '0) begin
      fails++; $display("FAIL mid_reset m=%0d got count=%0d empty=%b dout=%h", m, data_count[m],
                        empty[m], dout[m]);
    end
    cycle(m, 1'b1, 1'b0, DW'('h155), 1'b0);
    if (m == 1) begin
      cycle(m, 1'b0, 1'b0, '0, 1'b0);
      cycle(m, 1'b0, 1'b0, '0, 1'b0);
    end else begin
      cycle(m, 1'b0, 1'b1, '0, 1'b0);
    end
    tests++;
    if (dout[m] !== DW'('h155) || act_vec(m) !== exp_vec(m)) begin
      fails++; $display("FAIL mid_reset_data m=%0d got dout=%h want 155", m, dout[m]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      srst[i] = 1'b1; din[i] = '0; wr_en[i] = 1'b0; rd_en[i] = 1'b0;
      exp_wr_err[i] = 1'b0; exp_rd_err[i] = 1'b0;
    end
    last_dout0 = '0;
    test_reset(0);
    test_reset(1);
    test_fill_drain();
    test_fwft_single();
    test_back_to_back(0);
    test_back_to_back(1);
    test_wrap(0);
    test_wrap(1);
    test_prog_flags();
    test_reset_mid(0);
    test_reset_mid(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
